arbitro_memoria: RTL and testbench
==================================

Name: arbitro_memoria

Overview:
- Shares the nRisc 8-bit data memory between two requesters: port A (CPU load/store stage) and port B (debug/IO loader).
- Also provides a hardware clear sequencer that zeroes every word.
- Drives the memory's address/data/read/write inputs and returns its registered read data to the winning requester.
- Arbitration is round-robin. Each access uses a hold-until-ack handshake.

Parameters:
LARGURA, 8, data and address width
PROFUNDIDADE, 24, number of valid memory words (addresses 0..PROFUNDIDADE-1)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset
reqA  input  1  port A request, held until ackA
escrA  input  1  port A: 1=write, 0=read; stable while reqA
endA  input  LARGURA  port A address
dadoA  input  LARGURA  port A write data
ackA  output  1  one-cycle completion pulse, port A
erroA  output  1  with ackA: address out of range
reqB, escrB, endB, dadoB  input  1/1/LARGURA/LARGURA  port B, same rules as A
ackB, erroB  output  1/1  port B, same rules as A
dado_lido  output  LARGURA  read data, valid during ack of a read
limpa  input  1  one-cycle pulse requesting full clear
ocupado  output  1  high while a clear is pending or running
label  output  LARGURA  memory address
dado  output  LARGURA  memory write data
LerMemo  output  1  memory read strobe
EscrMemo  output  1  memory write strobe
dadoEscrito  input  LARGURA  memory registered read output

Behaviour:
- Reset (reset=0, async):
  - state OCIOSO.
  - label, dado, LerMemo, EscrMemo, ackA/B, erroA/B, ocupado, clear-pending flag all 0.
  - Round-robin pointer favours A.
  - Memory contents are not touched.
  - Reset mid-access aborts it: strobes drop immediately, no ack is issued.
- All outputs are registered, except dado_lido, which is a combinational pass-through of dadoEscrito.
- States: OCIOSO, ACESSO, RETORNO, LIMPA.
- OCIOSO, evaluated at each edge in this priority order:
  1. Clear pending or limpa=1 -> LIMPA; counter=0.
  2. Otherwise, one or more requests:
     - Only one requester -> grant it.
     - Both -> grant the one not served last.
     - Pointer updates on grant.
  3. Granted address >= PROFUNDIDADE -> RETORNO with erro set; no strobe ever asserted.
  4. Granted address valid -> ACESSO with label=end, dado=dado (write) and EscrMemo=escr, LerMemo=~escr.
- ACESSO (one cycle): strobes high, memory acts on the closing edge. Next state RETORNO; strobes cleared on entry.
- RETORNO (one cycle):
  - ack of the granted port = 1; erro as decided in OCIOSO.
  - Read: dado_lido holds the word read at the preceding edge.
  - Next state OCIOSO.
- Requester protocol:
  - Keep req and fields stable until ack.
  - Deassert req at the edge ending the ack cycle.
  - req sampled in OCIOSO only.
- Latency: valid access = 3 cycles from req sampled to return to OCIOSO; ack in the 3rd cycle. Out-of-range = 2 cycles.
- Throughput: back-to-back alternating A/B with no idle cycle between grants beyond OCIOSO.
- ackA and ackB are never high together.
- LIMPA:
  - Each cycle: EscrMemo=1, dado=0, label=counter; counter++.
  - Exit to OCIOSO after counter reaches PROFUNDIDADE-1; strobe cleared on exit.
  - Clear runs PROFUNDIDADE cycles.
  - ocupado=1 from the edge sampling limpa (or setting pending) until the exit edge.
- limpa while in ACESSO/RETORNO/LIMPA: latched as pending, ocupado=1; the clear starts at the next OCIOSO. A second limpa during LIMPA is ignored.
- Pending requests wait during LIMPA. Round-robin state is unchanged by a clear.
- LerMemo and EscrMemo are never high together.
- Memory sees no strobe in OCIOSO or RETORNO.

Test Plan:
- Reset release, reqA write endA=5 dadoA=0xA7 -> EscrMemo=1, label=5 in cycle 2; ackA in cycle 3; reqA read endA=5 -> ackA with dado_lido=0xA7.
- reqA and reqB both high from reset, A reads 3, B reads 4, held until ack -> order A, B, A, B; ackA and ackB never coincide; grants alternate.
- reqB read endB=30 (PROFUNDIDADE=24) -> ackB and erroB in cycle 2, LerMemo never asserted, memory unchanged.
- Write 0xFF to addresses 0 and 23, pulse limpa -> ocupado high, 24 consecutive EscrMemo cycles, label 0..23, dado=0; reads then return 0.
- limpa pulsed during an A write in ACESSO -> A write completes with ackA, then clear runs; reqB raised during clear is acknowledged only after ocupado falls.
- reset pulled low during ACESSO of a write -> EscrMemo drops asynchronously, no ackA, state OCIOSO after release.

Source files
------------

// File: rtl/arbitro_memoria.sv
// -----------------------------------------------------------------------------
// arbitro_memoria
//
// Shares the nRisc data memory between two requesters and a clear sequencer.
//   - Port A (CPU load/store stage) and port B (debug/IO loader) each use a
//     hold-until-ack handshake: req and its fields stay stable until a
//     one-cycle ack; err accompanies ack when the address is out of range.
//   - Requests are granted round-robin when both are pending.
//   - A one-cycle limpa pulse starts (or queues) a sequencer that writes zero
//     to every valid word; ocupado is high while it is queued or running.
//
// Ports
//   clk, reset          clock (posedge), asynchronous active-low reset
//   reqA/escrA/endA/dadoA   port A request, 1=write, address, write data
//   ackA/erroA          port A completion pulse and out-of-range flag
//   reqB/escrB/endB/dadoB   port B, same rules as port A
//   ackB/erroB          port B completion pulse and out-of-range flag
//   dado_lido           read data (pass-through of dadoEscrito), valid with ack
//   limpa/ocupado       clear request pulse / clear pending-or-running
//   label/dado          memory address / memory write data
//   LerMemo/EscrMemo    memory read / write strobes (never together)
//   dadoEscrito         registered read output of the memory
// -----------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reqA,
    input  logic               escrA,
    input  logic [LARGURA-1:0] endA,
    input  logic [LARGURA-1:0] dadoA,
    output logic               ackA,
    output logic               erroA,
    input  logic               reqB,
    input  logic               escrB,
    input  logic [LARGURA-1:0] endB,
    input  logic [LARGURA-1:0] dadoB,
    output logic               ackB,
    output logic               erroB,
    output logic [LARGURA-1:0] dado_lido,
    input  logic               limpa,
    output logic               ocupado,
    output logic [LARGURA-1:0] label,
    output logic [LARGURA-1:0] dado,
    output logic               LerMemo,
    output logic               EscrMemo,
    input  logic [LARGURA-1:0] dadoEscrito
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        ACESSO  = 2'b01,
        RETORNO = 2'b10,
        LIMPA   = 2'b11
    } estado_t;

    localparam logic [LARGURA-1:0] ZERO   = {LARGURA{1'b0}};
    localparam logic [LARGURA-1:0] UM     = {{(LARGURA-1){1'b0}}, 1'b1};
    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(PROFUNDIDADE - 1);
    // One bit wider than the address so a depth of 2**LARGURA does not wrap.
    localparam logic [LARGURA:0]   LIMITE = (LARGURA + 1)'(PROFUNDIDADE);

    estado_t            estado_q,   estado_d;
    logic [LARGURA-1:0] label_q,    label_d;     // also the clear counter
    logic [LARGURA-1:0] dado_q,     dado_d;
    logic               ler_q,      ler_d;
    logic               escr_q,     escr_d;
    logic               ack_a_q,    ack_a_d;
    logic               ack_b_q,    ack_b_d;
    logic               erro_a_q,   erro_a_d;
    logic               erro_b_q,   erro_b_d;
    logic               ocupado_q,  ocupado_d;
    logic               pendente_q, pendente_d;  // clear queued, not started
    logic               prio_b_q,   prio_b_d;    // 1: B wins a tie next time
    logic               gnt_b_q,    gnt_b_d;     // port owning the current access

    logic               escolhe_b_s;
    logic               escr_sel_s;
    logic [LARGURA-1:0] end_sel_s;
    logic [LARGURA-1:0] dado_sel_s;
    logic               fora_s;

    // B wins only when A is absent or B was not served last.
    assign escolhe_b_s = reqB & (~reqA | prio_b_q);
    assign escr_sel_s  = escolhe_b_s ? escrB : escrA;
    assign end_sel_s   = escolhe_b_s ? endB  : endA;
    assign dado_sel_s  = escolhe_b_s ? dadoB : dadoA;
    assign fora_s      = ({1'b0, end_sel_s} >= LIMITE);

    // Next-state and next-output logic for the arbitration/clear FSM.
    always_comb begin
        estado_d   = estado_q;
        label_d    = label_q;
        dado_d     = dado_q;
        ler_d      = 1'b0;
        escr_d     = 1'b0;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        erro_a_d   = 1'b0;
        erro_b_d   = 1'b0;
        ocupado_d  = ocupado_q;
        pendente_d = pendente_q;
        prio_b_d   = prio_b_q;
        gnt_b_d    = gnt_b_q;

        case (estado_q)
            OCIOSO: begin
                if (pendente_q || limpa) begin
                    // Clear has priority; waiting requests stay queued and
                    // the round-robin pointer is left alone.
                    estado_d   = LIMPA;
                    label_d    = ZERO;
                    dado_d     = ZERO;
                    escr_d     = 1'b1;
                    ocupado_d  = 1'b1;
                    pendente_d = 1'b0;
                end else if (reqA || reqB) begin
                    gnt_b_d  = escolhe_b_s;
                    prio_b_d = ~escolhe_b_s;
                    if (fora_s) begin
                        // Bad address: answer at once, memory never strobed.
                        estado_d = RETORNO;
                        ack_a_d  = ~escolhe_b_s;
                        ack_b_d  = escolhe_b_s;
                        erro_a_d = ~escolhe_b_s;
                        erro_b_d = escolhe_b_s;
                    end else begin
                        estado_d = ACESSO;
                        label_d  = end_sel_s;
                        dado_d   = escr_sel_s ? dado_sel_s : ZERO;
                        escr_d   = escr_sel_s;
                        ler_d    = ~escr_sel_s;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end

            ACESSO: begin
                // Memory acts on this closing edge; ack follows next cycle.
                estado_d = RETORNO;
                ack_a_d  = ~gnt_b_q;
                ack_b_d  = gnt_b_q;
                if (limpa) begin
                    pendente_d = 1'b1;
                    ocupado_d  = 1'b1;
                end else begin
                    pendente_d = pendente_q;
                end
            end

            RETORNO: begin
                estado_d = OCIOSO;
                if (limpa) begin
                    pendente_d = 1'b1;
                    ocupado_d  = 1'b1;
                end else begin
                    pendente_d = pendente_q;
                end
            end

            LIMPA: begin
                // A repeated limpa here is deliberately ignored.
                if (label_q == ULTIMO) begin
                    estado_d  = OCIOSO;
                    ocupado_d = 1'b0;
                end else begin
                    label_d = label_q + UM;
                    escr_d  = 1'b1;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and registered-output update; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            label_q    <= ZERO;
            dado_q     <= ZERO;
            ler_q      <= 1'b0;
            escr_q     <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            erro_a_q   <= 1'b0;
            erro_b_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            pendente_q <= 1'b0;
            prio_b_q   <= 1'b0;
            gnt_b_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            label_q    <= label_d;
            dado_q     <= dado_d;
            ler_q      <= ler_d;
            escr_q     <= escr_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            erro_a_q   <= erro_a_d;
            erro_b_q   <= erro_b_d;
            ocupado_q  <= ocupado_d;
            pendente_q <= pendente_d;
            prio_b_q   <= prio_b_d;
            gnt_b_q    <= gnt_b_d;
        end
    end

    assign label     = label_q;
    assign dado      = dado_q;
    assign LerMemo   = ler_q;
    assign EscrMemo  = escr_q;
    assign ackA      = ack_a_q;
    assign ackB      = ack_b_q;
    assign erroA     = erro_a_q;
    assign erroB     = erro_b_q;
    assign ocupado   = ocupado_q;
    // The memory output is already registered, so it is passed straight on.
    assign dado_lido = dadoEscrito;

endmodule

// File: tb/tb_arbitro_memoria.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria
//
// Drives arbitro_memoria with a small behavioural memory behind it and checks
// results against a reference word array plus a round-robin priority flag.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam int P = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reqA = 1'b0, escrA = 1'b0, reqB = 1'b0, escrB = 1'b0;
    logic       limpa = 1'b0;
    logic [7:0] endA = 8'd0, dadoA = 8'd0, endB = 8'd0, dadoB = 8'd0;
    logic [7:0] dadoEscrito = 8'd0;
    logic       ackA, erroA, ackB, erroB, ocupado, LerMemo, EscrMemo;
    logic [7:0] dado_lido, label, dado;

    int         errors = 0;
    int         checks = 0;
    int         strobes = 0;
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:P-1];
    bit         fav_b = 1'b0;

    arbitro_memoria #(.LARGURA(8), .PROFUNDIDADE(P)) dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .escrA(escrA), .endA(endA), .dadoA(dadoA),
        .ackA(ackA), .erroA(erroA),
        .reqB(reqB), .escrB(escrB), .endB(endB), .dadoB(dadoB),
        .ackB(ackB), .erroB(erroB),
        .dado_lido(dado_lido), .limpa(limpa), .ocupado(ocupado),
        .label(label), .dado(dado), .LerMemo(LerMemo), .EscrMemo(EscrMemo),
        .dadoEscrito(dadoEscrito)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    end

    // Memory with registered read output.
    always @(posedge clk) begin
        if (EscrMemo) mem[label] <= dado;
        if (LerMemo) dadoEscrito <= mem[label];
        if (LerMemo || EscrMemo) strobes <= strobes + 1;
    end

    // Invariants checked every cycle.
    always @(negedge clk) begin
        checks++;
        if (ackA && ackB) begin
            errors++;
            $display("FAIL ack_exclusive: ackA=%0b ackB=%0b required not both", ackA, ackB);
        end
        checks++;
        if (LerMemo && EscrMemo) begin
            errors++;
            $display("FAIL strobe_exclusive: LerMemo=%0b EscrMemo=%0b required not both", LerMemo, EscrMemo);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        reqA = 1'b0; reqB = 1'b0; limpa = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        fav_b = 1'b0;
    endtask

    // Single-port transaction driver; returns cycles-to-ack (-1 on timeout).
    task automatic acesso(input bit b, input bit w, input logic [7:0] a,
                          input logic [7:0] d, output int lat, output bit err,
                          output logic [7:0] rd);
        bit got;
        got = 1'b0; lat = -1; err = 1'b0; rd = 8'd0;
        if (b) begin reqB = 1'b1; escrB = w; endB = a; dadoB = d; end
        else   begin reqA = 1'b1; escrA = w; endA = a; dadoA = d; end
        for (int n = 1; n <= 60 && !got; n++) begin
            tick();
            if ((b ? ackB : ackA) === 1'b1) begin
                got = 1'b1; lat = n; err = b ? erroB : erroA; rd = dado_lido;
            end
        end
        tick();
        reqA = 1'b0; reqB = 1'b0;
        fav_b = !b;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        #2;
        obs = {label, dado, LerMemo, EscrMemo, ackA, ackB, erroA, erroB, ocupado};
        checks++;
        if (obs !== 23'd0) begin errors++; $display("FAIL reset_outputs: got %h required 0", obs); end
        apply_reset();
        obs = {label, dado, LerMemo, EscrMemo, ackA, ackB, erroA, erroB, ocupado};
        checks++;
        if (obs !== 23'd0) begin errors++; $display("FAIL reset_release_outputs: got %h required 0", obs); end
        checks++;
        if (dado_lido !== dadoEscrito) begin
            errors++; $display("FAIL dado_lido_passthru: got %h required %h", dado_lido, dadoEscrito);
        end
    endtask

    task automatic test_write_read();
        int lat; bit err; logic [7:0] rd;
        reqA = 1'b1; escrA = 1'b1; endA = 8'd5; dadoA = 8'hA7;
        tick();
        checks++;
        if ({EscrMemo, LerMemo, label, dado, ackA} !== {1'b1, 1'b0, 8'd5, 8'hA7, 1'b0}) begin
            errors++;
            $display("FAIL wr_cycle2: EscrMemo=%0b LerMemo=%0b label=%0d dado=%h ackA=%0b required 1 0 5 a7 0",
                     EscrMemo, LerMemo, label, dado, ackA);
        end
        tick();
        checks++;
        if ({ackA, erroA, EscrMemo} !== 3'b100) begin
            errors++; $display("FAIL wr_ack_cycle3: ackA,erroA,EscrMemo=%b required 100", {ackA, erroA, EscrMemo});
        end
        tick();
        reqA = 1'b0;
        fav_b = 1'b1;
        checks++;
        if (ackA !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: ackA=%0b required 0", ackA); end
        ref_mem[5] = 8'hA7;
        acesso(1'b0, 1'b0, 8'd5, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== ref_mem[5]) begin
            errors++; $display("FAIL rd_after_wr: lat=%0d err=%0b data=%h required 2 0 %h", lat, err, rd, ref_mem[5]);
        end
    endtask

    task automatic test_round_robin();
        int   acks; int when [4]; bit who [4]; logic [7:0] rdv [4];
        apply_reset();
        acks = 0;
        reqA = 1'b1; escrA = 1'b0; endA = 8'd3;
        reqB = 1'b1; escrB = 1'b0; endB = 8'd4;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            tick();
            if (ackA === 1'b1) begin who[acks] = 1'b0; when[acks] = c; rdv[acks] = dado_lido; acks++; end
            else if (ackB === 1'b1) begin who[acks] = 1'b1; when[acks] = c; rdv[acks] = dado_lido; acks++; end
        end
        tick();
        reqA = 1'b0; reqB = 1'b0;
        fav_b = 1'b0;
        checks++;
        if (acks !== 4) begin errors++; $display("FAIL rr_ack_count: got %0d required 4", acks); end
        for (int k = 0; k < acks; k++) begin
            checks++;
            if (who[k] !== k[0] || when[k] !== 2 + 3 * k || rdv[k] !== ref_mem[k[0] ? 4 : 3]) begin
                errors++;
                $display("FAIL rr_grant%0d: port=%0d cycle=%0d data=%h required port=%0d cycle=%0d data=%h",
                         k, who[k], when[k], rdv[k], k[0], 2 + 3 * k, ref_mem[k[0] ? 4 : 3]);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat; bit err; logic [7:0] rd; int s0; int bad;
        s0 = strobes;
        acesso(1'b1, 1'b0, 8'd30, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL oor_read30_B: lat=%0d err=%0b required 1 1", lat, err); end
        acesso(1'b0, 1'b1, 8'd24, 8'h55, lat, err, rd);
        checks++;
        if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL oor_write24_A: lat=%0d err=%0b required 1 1", lat, err); end
        acesso(1'b1, 1'b0, 8'd23, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== ref_mem[23]) begin
            errors++; $display("FAIL edge_read23: lat=%0d err=%0b data=%h required 2 0 %h", lat, err, rd, ref_mem[23]);
        end
        checks++;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL oor_strobes: got %0d required 1", strobes - s0); end
        bad = 0;
        for (int i = 0; i < P; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL oor_mem_intact: %0d words differ, required 0", bad); end
    endtask

    task automatic test_clear();
        int lat; bit err; logic [7:0] rd; int n; int bad;
        acesso(1'b0, 1'b1, 8'd0, 8'hFF, lat, err, rd);
        ref_mem[0] = 8'hFF;
        acesso(1'b1, 1'b1, 8'd23, 8'hFF, lat, err, rd);
        ref_mem[23] = 8'hFF;
        checks++;
        if (mem[0] !== 8'hFF || mem[23] !== 8'hFF) begin
            errors++; $display("FAIL clr_prefill: mem0=%h mem23=%h required ff ff", mem[0], mem[23]);
        end
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        n = 0; bad = 0;
        while (EscrMemo === 1'b1 && n < 40) begin
            if (label !== n[7:0] || dado !== 8'd0 || ocupado !== 1'b1) bad++;
            n++;
            tick();
        end
        checks++;
        if (n !== P || bad !== 0) begin errors++; $display("FAIL clr_sequence: cycles=%0d bad=%0d required %0d 0", n, bad, P); end
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL clr_ocupado_end: got %0b required 0", ocupado); end
        for (int i = 0; i < P; i++) ref_mem[i] = 8'd0;
        acesso(1'b0, 1'b0, 8'd0, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 2 || rd !== 8'd0) begin errors++; $display("FAIL clr_read0: lat=%0d data=%h required 2 0", lat, rd); end
        acesso(1'b1, 1'b0, 8'd23, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 2 || rd !== 8'd0) begin errors++; $display("FAIL clr_read23: lat=%0d data=%h required 2 0", lat, rd); end
    endtask

    task automatic test_clear_during_access();
        int lat; bit got; logic [7:0] rd; bit occ;
        reqA = 1'b1; escrA = 1'b1; endA = 8'd7; dadoA = 8'h5C;
        tick();
        checks++;
        if (EscrMemo !== 1'b1) begin errors++; $display("FAIL cda_in_access: EscrMemo=%0b required 1", EscrMemo); end
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        checks++;
        if ({ackA, ocupado} !== 2'b11) begin errors++; $display("FAIL cda_ack_pending: ackA,ocupado=%b required 11", {ackA, ocupado}); end
        tick();
        reqA = 1'b0;
        reqB = 1'b1; escrB = 1'b0; endB = 8'd7;
        got = 1'b0; lat = -1; rd = 8'd0; occ = 1'b1;
        for (int n = 1; n <= 60 && !got; n++) begin
            tick();
            limpa = (n == 5);   // repeated clear inside LIMPA must not extend it
            if (ackB === 1'b1) begin got = 1'b1; lat = n; rd = dado_lido; occ = ocupado; end
        end
        limpa = 1'b0;
        tick();
        reqB = 1'b0;
        fav_b = 1'b0;
        ref_mem[7] = 8'd0;
        checks++;
        if (lat !== 27 || occ !== 1'b0 || rd !== ref_mem[7]) begin
            errors++; $display("FAIL cda_B_after_clear: lat=%0d ocupado=%0b data=%h required 27 0 00", lat, occ, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat; bit err; logic [7:0] rd; bit saw_ack;
        reqA = 1'b1; escrA = 1'b1; endA = 8'd9; dadoA = 8'h3C;
        tick();
        checks++;
        if (EscrMemo !== 1'b1) begin errors++; $display("FAIL rma_in_access: EscrMemo=%0b required 1", EscrMemo); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({EscrMemo, LerMemo, ackA} !== 3'b000) begin
            errors++; $display("FAIL rma_async_drop: EscrMemo,LerMemo,ackA=%b required 000", {EscrMemo, LerMemo, ackA});
        end
        reqA = 1'b0;
        saw_ack = 1'b0;
        @(posedge clk); #1; saw_ack = saw_ack | ackA;
        @(posedge clk); #3;
        reset = 1'b1;
        tick(); saw_ack = saw_ack | ackA;
        tick(); saw_ack = saw_ack | ackA;
        fav_b = 1'b0;
        checks++;
        if (saw_ack !== 1'b0 || ocupado !== 1'b0) begin
            errors++; $display("FAIL rma_no_ack: ack_seen=%0b ocupado=%0b required 0 0", saw_ack, ocupado);
        end
        acesso(1'b0, 1'b0, 8'd9, 8'd0, lat, err, rd);
        checks++;
        if (lat !== 2 || rd !== ref_mem[9]) begin
            errors++; $display("FAIL rma_mem_kept: lat=%0d data=%h required 2 %h", lat, rd, ref_mem[9]);
        end
    endtask

    task automatic test_random();
        int mode; int lat; bit err; logic [7:0] rd;
        bit w [2]; logic [7:0] a [2]; logic [7:0] d [2];
        int nobs [2]; bit eobs [2]; logic [7:0] robs [2]; bit got [2]; bit drop [2];
        int first; int p; int exp_n; int prev_n; bit valid;
        for (int it = 0; it < 60; it++) begin
            mode = $urandom_range(0, 2);
            for (int q = 0; q < 2; q++) begin
                w[q] = 1'($urandom_range(0, 1));
                a[q] = 8'($urandom_range(0, 31));
                d[q] = 8'($urandom);
            end
            if (mode < 2) begin
                acesso(mode[0], w[0], a[0], d[0], lat, err, rd);
                valid = (a[0] < P);
                checks++;
                if (lat !== (valid ? 2 : 1) || err !== !valid || (valid && !w[0] && rd !== ref_mem[a[0]])) begin
                    errors++;
                    $display("FAIL rnd_single%0d: port=%0d w=%0b addr=%0d lat=%0d err=%0b data=%h required lat=%0d err=%0b data=%h",
                             it, mode, w[0], a[0], lat, err, rd, valid ? 2 : 1, !valid, valid ? ref_mem[a[0]] : 8'd0);
                end
                if (valid && w[0]) ref_mem[a[0]] = d[0];
            end else begin
                reqA = 1'b1; escrA = w[0]; endA = a[0]; dadoA = d[0];
                reqB = 1'b1; escrB = w[1]; endB = a[1]; dadoB = d[1];
                got[0] = 1'b0; got[1] = 1'b0; drop[0] = 1'b0; drop[1] = 1'b0;
                nobs[0] = -1; nobs[1] = -1;
                for (int n = 1; n <= 30 && !(got[0] && got[1]); n++) begin
                    tick();
                    if (drop[0]) begin reqA = 1'b0; drop[0] = 1'b0; end
                    if (drop[1]) begin reqB = 1'b0; drop[1] = 1'b0; end
                    if (ackA === 1'b1) begin got[0] = 1'b1; nobs[0] = n; eobs[0] = erroA; robs[0] = dado_lido; drop[0] = 1'b1; end
                    if (ackB === 1'b1) begin got[1] = 1'b1; nobs[1] = n; eobs[1] = erroB; robs[1] = dado_lido; drop[1] = 1'b1; end
                end
                tick();
                reqA = 1'b0; reqB = 1'b0;
                first = fav_b ? 1 : 0;
                prev_n = 0;
                for (int k = 0; k < 2; k++) begin
                    p = (k == 0) ? first : 1 - first;
                    valid = (a[p] < P);
                    exp_n = prev_n + (k == 0 ? 0 : 1) + (valid ? 2 : 1);
                    checks++;
                    if (nobs[p] !== exp_n || eobs[p] !== !valid || (valid && !w[p] && robs[p] !== ref_mem[a[p]])) begin
                        errors++;
                        $display("FAIL rnd_dual%0d_port%0d: cycle=%0d err=%0b data=%h required cycle=%0d err=%0b data=%h",
                                 it, p, nobs[p], eobs[p], robs[p], exp_n, !valid, valid ? ref_mem[a[p]] : 8'd0);
                    end
                    if (valid && w[p]) ref_mem[a[p]] = d[p];
                    prev_n = exp_n;
                end
                fav_b = (first == 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < P; i++) ref_mem[i] = 8'(i * 37 + 11);
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_clear();
        test_clear_during_access();
        test_reset_mid_access();
        test_random();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
